// File: rtl/aes_pkg.sv
// Shared AES datapath constants and types.
// Used by the FIFO read-side block assembler and its neighbours.
package aes_pkg;

    localparam int AES_BLK_BYTES = 16;
    localparam int AES_BYTE_W    = 8;

    typedef enum logic {
        RDR_COLLECT,
        RDR_HOLD
    } rdr_state_t;

    typedef logic [127:0] aes_blk_t;

endpackage

// File: rtl/mod_fifo_reader.sv
// Drains a byte FIFO and assembles BYTES consecutive bytes into one block,
// offered to the cipher core over valid/ready and held until accepted.
//
// state       | meaning
// RDR_COLLECT | popping bytes and capturing them into blk_out slots
// RDR_HOLD    | block complete, blk_valid high, waiting for blk_ready
module mod_fifo_reader
    import aes_pkg::*;
#(
    parameter int BYTES = AES_BLK_BYTES,
    parameter int DW    = AES_BYTE_W
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clr,
    input  logic [DW-1:0]                buf_out,
    input  logic                         buf_empty,
    output logic                         rd_en,
    output logic [BYTES*DW-1:0]          blk_out,
    output logic                         blk_valid,
    input  logic                         blk_ready,
    output logic [$clog2(BYTES+1)-1:0]   byte_cnt
);

    localparam int CW = $clog2(BYTES + 1);
    localparam int IW = $clog2(BYTES * DW);
    localparam logic [CW-1:0] CNT_FULL = CW'(BYTES);
    localparam logic [CW-1:0] CNT_LAST = CW'(BYTES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    rdr_state_t    state;
    logic [CW-1:0] issued;
    logic          pend;
    logic          pop;
    logic [IW-1:0] slot_lsb;

    assign rd_en    = rst && (state == RDR_COLLECT) && (issued < CNT_FULL) && !clr;
    assign pop      = rd_en && !buf_empty;
    // Slot 0 sits in the MSBs; only meaningful while byte_cnt < BYTES.
    assign slot_lsb = IW'((BYTES - 1 - int'(byte_cnt)) * DW);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= RDR_COLLECT;
            issued    <= '0;
            pend      <= 1'b0;
            byte_cnt  <= '0;
            blk_valid <= 1'b0;
            blk_out   <= '0;
        end else if (clr) begin
            // blk_out is left as is; the next block overwrites every slot.
            state     <= RDR_COLLECT;
            issued    <= '0;
            pend      <= 1'b0;
            byte_cnt  <= '0;
            blk_valid <= 1'b0;
        end else begin
            case (state)
                RDR_COLLECT: begin
                    pend <= pop;
                    if (pop) begin
                        issued <= issued + CNT_ONE;
                    end
                    if (pend) begin
                        blk_out[slot_lsb +: DW] <= buf_out;
                        byte_cnt                <= byte_cnt + CNT_ONE;
                        if (byte_cnt == CNT_LAST) begin
                            state     <= RDR_HOLD;
                            blk_valid <= 1'b1;
                        end
                    end
                end
                RDR_HOLD: begin
                    if (blk_ready) begin
                        state     <= RDR_COLLECT;
                        issued    <= '0;
                        byte_cnt  <= '0;
                        blk_valid <= 1'b0;
                    end
                end
                default: state <= RDR_COLLECT;
            endcase
        end
    end

endmodule

// File: tb/tb_mod_fifo_reader.sv
// Bench for mod_fifo_reader: a queue-based byte FIFO feeds the reader and a
// reference list of sent bytes predicts every assembled block.
module tb_mod_fifo_reader;
    import aes_pkg::*;

    localparam int BYTES = AES_BLK_BYTES;
    localparam int DW    = AES_BYTE_W;

    logic                         clk = 1'b0;
    logic                         rst;
    logic                         clr = 1'b0;
    logic [DW-1:0]                buf_out = '0;
    logic                         buf_empty = 1'b1;
    logic                         rd_en;
    logic [BYTES*DW-1:0]          blk_out;
    logic                         blk_valid;
    logic                         blk_ready = 1'b0;
    logic [$clog2(BYTES+1)-1:0]   byte_cnt;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;
    int pops   = 0;
    int fifo_cap = 1;
    bit gap_mode = 1'b0;

    logic [7:0] fq[$];
    logic [7:0] push_q[$];
    logic [7:0] ref_q[$];

    mod_fifo_reader #(.BYTES(BYTES), .DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .buf_out   (buf_out),
        .buf_empty (buf_empty),
        .rd_en     (rd_en),
        .blk_out   (blk_out),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .byte_cnt  (byte_cnt)
    );

    always #5 clk = ~clk;

    // FIFO model: registered read data, pop gated by emptiness, bounded depth.
    always @(posedge clk) begin
        bit push_ok;
        if (rd_en && fq.size() > 0) begin
            buf_out <= fq.pop_front();
            pops++;
        end
        push_ok = !gap_mode || ($urandom_range(0, 2) != 0);
        if (push_ok && push_q.size() > 0 && fq.size() < fifo_cap)
            fq.push_back(push_q.pop_front());
        buf_empty <= (fq.size() == 0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cycle++;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        push_q.push_back(b);
        ref_q.push_back(b);
    endtask

    task automatic send_rand(input int n);
        for (int i = 0; i < n; i++) send(8'($urandom_range(0, 255)));
    endtask

    function automatic logic [127:0] next_block();
        logic [127:0] blk;
        blk = '0;
        for (int i = 0; i < BYTES; i++) begin
            if (ref_q.size() > 0) blk = {blk[119:0], ref_q.pop_front()};
            else                  blk = {blk[119:0], 8'hxx};
        end
        return blk;
    endfunction

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 300 && !blk_valid; i++) tick();
        chk(tag, blk_valid, 1'b1);
    endtask

    task automatic wait_cnt(input string tag, input int n);
        for (int i = 0; i < 300 && byte_cnt != n; i++) tick();
        chk(tag, byte_cnt, n);
    endtask

    task automatic handshake();
        blk_ready = 1'b1;
        tick();
        blk_ready = 1'b0;
    endtask

    initial begin
        logic [127:0] exp;
        int base;
        int c1;

        // reset
        rst = 1'b0;
        tick();
        chk("rst_blk_out", blk_out, '0);
        chk("rst_valid", blk_valid, 1'b0);
        chk("rst_cnt", byte_cnt, 0);
        chk("rst_rd_en", rd_en, 1'b0);
        tick();
        rst = 1'b1;
        #1;
        chk("rel_rd_en", rd_en, 1'b1);

        // first block 00..0F through a 1-entry FIFO
        for (int b = 0; b < 16; b++) send(8'(b));
        wait_valid("blk1_valid");
        exp = next_block();
        chk("blk1_data", blk_out, exp);
        chk("blk1_const", blk_out, 128'h000102030405060708090a0b0c0d0e0f);
        chk("blk1_cnt", byte_cnt, 16);

        // held block with a waiting byte in the FIFO
        base = pops;
        send(8'hAA);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("hold_data", blk_out, exp);
            chk("hold_rd_en", rd_en, 1'b0);
            chk("hold_valid", blk_valid, 1'b1);
        end
        chk("hold_no_pop", pops, base);
        chk("hold_fifo_full", buf_empty, 1'b0);
        handshake();
        chk("hs_valid", blk_valid, 1'b0);
        chk("hs_cnt", byte_cnt, 0);
        chk("hs_rd_en", rd_en, 1'b1);
        for (int b = 1; b < 16; b++) send(8'(b));
        wait_valid("blk2_valid");
        chk("blk2_data", blk_out, next_block());
        handshake();

        // FIFO runs empty after byte 7
        send_rand(7);
        wait_cnt("gap_cnt7", 7);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("gap_rd_en", rd_en, 1'b1);
            chk("gap_cnt", byte_cnt, 7);
        end
        send_rand(9);
        wait_valid("gap_valid");
        chk("gap_data", blk_out, next_block());
        handshake();

        // clear with a popped byte still in flight
        base = pops;
        send_rand(10);
        for (int i = 0; i < 100 && pops != base + 10; i++) tick();
        chk("clr_pops", pops, base + 10);
        chk("clr_pre_cnt", byte_cnt, 9);
        clr = 1'b1;
        #1;
        chk("clr_rd_en", rd_en, 1'b0);
        tick();
        clr = 1'b0;
        chk("clr_cnt", byte_cnt, 0);
        chk("clr_valid", blk_valid, 1'b0);
        ref_q.delete();
        for (int b = 16; b < 32; b++) send(8'(b));
        wait_valid("clr_blk_valid");
        exp = next_block();
        chk("clr_blk_data", blk_out, exp);
        chk("clr_blk_const", blk_out, 128'h101112131415161718191a1b1c1d1e1f);
        handshake();

        // asynchronous reset mid-block
        send_rand(12);
        wait_cnt("arst_cnt12", 12);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_valid", blk_valid, 1'b0);
        chk("arst_cnt", byte_cnt, 0);
        chk("arst_rd_en", rd_en, 1'b0);
        chk("arst_blk_out", blk_out, '0);
        tick();
        tick();
        rst = 1'b1;
        ref_q.delete();
        send_rand(16);
        wait_valid("arst_blk_valid");
        chk("arst_blk_data", blk_out, next_block());
        handshake();

        // handshake and clear on the same edge
        send_rand(16);
        wait_valid("hsclr_valid_pre");
        blk_ready = 1'b1;
        clr = 1'b1;
        tick();
        blk_ready = 1'b0;
        clr = 1'b0;
        chk("hsclr_valid", blk_valid, 1'b0);
        chk("hsclr_cnt", byte_cnt, 0);
        ref_q.delete();

        // back-to-back blocks with an always-full FIFO
        send_rand(32);
        blk_ready = 1'b1;
        wait_valid("tp_valid1");
        c1 = cycle;
        chk("tp_data1", blk_out, next_block());
        tick();
        wait_valid("tp_valid2");
        chk("tp_period", cycle - c1, BYTES + 2);
        chk("tp_data2", blk_out, next_block());
        tick();
        blk_ready = 1'b0;

        // random gaps, deeper FIFO, random consumer stalls
        gap_mode = 1'b1;
        fifo_cap = 3;
        for (int n = 0; n < 5; n++) begin
            send_rand(16);
            wait_valid("rnd_valid");
            exp = next_block();
            chk("rnd_data", blk_out, exp);
            chk("rnd_cnt", byte_cnt, 16);
            repeat ($urandom_range(0, 5)) begin
                tick();
                chk("rnd_hold", blk_out, exp);
            end
            handshake();
        end
        gap_mode = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
